// File: rtl/or_reduce_acc.sv
// or_reduce_acc: bitwise OR of CH channels of W bits per accepted beat, with a
// registered valid/ready result, a saturating beat count and an any-bit flag.
// Build option: define OR_REDUCE_ACC_EN to OR-accumulate beats across a frame
// closed by in_last; when undefined, every accepted beat is its own frame.
module or_reduce_acc #(
   parameter int W  = 8,
   parameter int CH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CH*W-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_any,
   output logic [7:0]    out_beats
);

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] beat_or;
   logic         accept;
   logic         deliver;
   logic         last_beat;
   logic [W-1:0] frame_or;
   logic [7:0]   frame_beats;

   // OR all channels of the current beat together.
   // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      beat_or = '0;
      for (int k = 0; k < CH; k++) begin
         beat_or = beat_or | in_data[k*W +: W];
      end
   end

   // A held result blocks new beats only until the consumer takes it.
   assign out_valid = (state == FULL);
   assign in_ready  = (state == COLLECT) || out_ready;
   assign accept    = in_valid && in_ready;
   assign deliver   = out_valid && out_ready;

`ifdef OR_REDUCE_ACC_EN
   logic [W-1:0] acc;
   logic [7:0]   cnt;

   assign last_beat   = in_last;
   assign frame_or    = acc | beat_or;
   assign frame_beats = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;

   // Running OR and saturating beat count of the frame in progress.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         if (last_beat) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= frame_or;
            cnt <= frame_beats;
         end
      end
   end
`else
   logic unused_last;

   // Without accumulation each beat closes a one-beat frame; in_last is ignored.
   assign unused_last = in_last;
   assign last_beat   = 1'b1;
   assign frame_or    = beat_or;
   assign frame_beats = 8'd1;
`endif

   // Result registers load only when a frame closes and otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_any   <= 1'b0;
         out_beats <= '0;
      end else if (accept && last_beat) begin
         out_data  <= frame_or;
         out_any   <= |frame_or;
         out_beats <= frame_beats;
      end
   end

   // State register for the result-holding FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a closing beat always (re)fills; a delivery alone empties.
   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: begin
            if (accept && last_beat) state_nxt = FULL;
         end
         FULL: begin
            if (accept && last_beat) state_nxt = FULL;
            else if (deliver)        state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

endmodule
